// File: rtl/alu4_acc_ctrl_if.sv
// Command channel of the alu4 accumulator controller.
// A command is one of: load accumulator with cmd_b (cmd_ld=1), or run ALU
// opcode cmd_op with operand cmd_b against the accumulator (cmd_ld=0).
// Transfer happens on a rising clock edge where cmd_valid and cmd_ready are both high.
//   cmd_valid  master->slave  command present
//   cmd_ready  slave->master  controller idle, command can be taken
//   cmd_ld     master->slave  1: load, 0: ALU operation
//   cmd_op     master->slave  ALU opcode
//   cmd_b      master->slave  operand b / load value
interface alu4_acc_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_ld;
    logic [2:0] cmd_op;
    logic [3:0] cmd_b;

    modport master (
        output cmd_valid,
        output cmd_ld,
        output cmd_op,
        output cmd_b,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_ld,
        input  cmd_op,
        input  cmd_b,
        output cmd_ready
    );
endinterface

// File: rtl/alu4_acc_ctrl.sv
// Accumulator/sequencer around the combinational 4-bit ALU (alu4).
// Takes load / ALU commands over the cmd interface, presents acc, b_q and
// op_q to the ALU for one full cycle, then writes the ALU result back into
// the accumulator and captures the c/n/z/v flags.
//
// Optional feature macro: ACC_STICKY_OV_EN
//   defined   : ov_sticky latches alu_v on each write-back, ov_clr clears it
//               (a set on the same edge wins over the clear)
//   undefined : ov_sticky tied low, ov_clr ignored
//
// Ports
//   clk, reset_n         clock (rising edge), async active-low reset
//   cmd                  command channel (slave side)
//   alu_a/alu_b/alu_op   to alu4 (registered: acc, b_q, op_q)
//   alu_result, alu_c/n/z/v  from alu4
//   acc                  accumulator
//   flag_c/n/z/v         registered ALU flags
//   done                 one-cycle pulse after each completed command
//   ov_clr, ov_sticky    sticky overflow clear / status
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | ready for a command; loads complete here in one edge
// EXEC   | ALU inputs held stable; next edge writes result and flags
module alu4_acc_ctrl #(
    parameter logic [3:0] ACC_INIT = 4'b0000
) (
    input  logic           clk,
    input  logic           reset_n,
    alu4_acc_ctrl_if.slave cmd,
    output logic [3:0]     alu_a,
    output logic [3:0]     alu_b,
    output logic [2:0]     alu_op,
    input  logic [3:0]     alu_result,
    input  logic           alu_c,
    input  logic           alu_n,
    input  logic           alu_z,
    input  logic           alu_v,
    output logic [3:0]     acc,
    output logic           flag_c,
    output logic           flag_n,
    output logic           flag_z,
    output logic           flag_v,
    output logic           done,
    input  logic           ov_clr,
    output logic           ov_sticky
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic       ready_int;
    logic       ld_fire;
    logic       op_fire;
    logic       write_back;
    logic [3:0] b_q;
    logic [2:0] op_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ready_int  = 1'b0;
        ld_fire    = 1'b0;
        op_fire    = 1'b0;
        write_back = 1'b0;
        case (state)
            S_IDLE: begin
                ready_int = 1'b1;
                if (cmd.cmd_valid) begin
                    if (cmd.cmd_ld) begin
                        ld_fire = 1'b1;
                    end else begin
                        op_fire   = 1'b1;
                        state_nxt = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                write_back = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign cmd.cmd_ready = ready_int;

    // Datapath: accumulator, latched operands and flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc    <= ACC_INIT;
            b_q    <= 4'h0;
            op_q   <= 3'b000;
            flag_c <= 1'b0;
            flag_n <= 1'b0;
            flag_z <= 1'b0;
            flag_v <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= ld_fire | write_back;
            if (ld_fire) begin
                acc <= cmd.cmd_b;
            end
            if (op_fire) begin
                b_q  <= cmd.cmd_b;
                op_q <= cmd.cmd_op;
            end
            if (write_back) begin
                acc    <= alu_result;
                flag_c <= alu_c;
                flag_n <= alu_n;
                flag_z <= alu_z;
                flag_v <= alu_v;
            end
        end
    end

    assign alu_a  = acc;
    assign alu_b  = b_q;
    assign alu_op = op_q;

`ifdef ACC_STICKY_OV_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ov_sticky <= 1'b0;
        end else if (write_back && alu_v) begin
            ov_sticky <= 1'b1;
        end else if (ov_clr) begin
            ov_sticky <= 1'b0;
        end
    end
`else
    // Port kept for a uniform pinout; the clear has nothing to act on.
    logic unused_ov_clr;
    assign unused_ov_clr = ov_clr;
    assign ov_sticky     = 1'b0;
`endif

endmodule

// File: tb/tb_alu4_acc_ctrl.sv
module tb_alu4_acc_ctrl;
    localparam logic [3:0] ACC_INIT = 4'b0000;

    logic       clk;
    logic       reset_n;
    logic [3:0] alu_a, alu_b, alu_result, acc;
    logic [2:0] alu_op;
    logic       alu_c, alu_n, alu_z, alu_v;
    logic       flag_c, flag_n, flag_z, flag_v;
    logic       done, ov_clr, ov_sticky;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    alu4_acc_ctrl_if cif ();

    alu4_acc_ctrl #(.ACC_INIT(ACC_INIT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd        (cif.slave),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_c      (alu_c),
        .alu_n      (alu_n),
        .alu_z      (alu_z),
        .alu_v      (alu_v),
        .acc        (acc),
        .flag_c     (flag_c),
        .flag_n     (flag_n),
        .flag_z     (flag_z),
        .flag_v     (flag_v),
        .done       (done),
        .ov_clr     (ov_clr),
        .ov_sticky  (ov_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic definition of alu4: returns {result, c, n, z, v}.
    // Subtract carry means "no borrow" (a >= b unsigned).
    function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
        int ua, ub, sa, sb, s;
        logic [3:0] r;
        logic c, v;
        ua = int'(a); ub = int'(b);
        sa = (ua > 7) ? ua - 16 : ua;
        sb = (ub > 7) ? ub - 16 : ub;
        c = 1'b0; v = 1'b0;
        case (op)
            3'd0: r = ~a;
            3'd1: r = ~b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~(a ^ b);
            3'd6: begin
                r = 4'((ua + ub) % 16);
                c = (ua + ub) > 15;
                s = sa + sb;
                v = (s > 7) || (s < -8);
            end
            default: begin
                r = 4'((ua - ub + 16) % 16);
                c = ua >= ub;
                s = sa - sb;
                v = (s > 7) || (s < -8);
            end
        endcase
        return {r, c, r[3], (r == 4'h0), v};
    endfunction

    // Stand-in for alu4.
    assign {alu_result, alu_c, alu_n, alu_z, alu_v} = alu_f(alu_a, alu_b, alu_op);

    // Reference model: what the controller's visible outputs must be.
    logic [3:0] m_acc, m_b, m_flags;
    logic [2:0] m_op;
    logic       m_busy, m_done, m_ov;

    always @(posedge clk or negedge reset_n) begin
        logic [7:0] res;
        logic       set_ov;
        if (!reset_n) begin
            m_acc = ACC_INIT; m_b = 4'h0; m_op = 3'b000; m_flags = 4'h0;
            m_busy = 1'b0; m_done = 1'b0; m_ov = 1'b0;
        end else begin
            set_ov = 1'b0;
            m_done = 1'b0;
            if (m_busy) begin
                res     = alu_f(m_acc, m_b, m_op);
                m_acc   = res[7:4];
                m_flags = res[3:0];
                set_ov  = res[0];
                m_busy  = 1'b0;
                m_done  = 1'b1;
            end else if (cif.cmd_valid) begin
                if (cif.cmd_ld) begin
                    m_acc  = cif.cmd_b;
                    m_done = 1'b1;
                end else begin
                    m_op   = cif.cmd_op;
                    m_b    = cif.cmd_b;
                    m_busy = 1'b1;
                end
            end
`ifdef ACC_STICKY_OV_EN
            if (set_ov) m_ov = 1'b1;
            else if (ov_clr) m_ov = 1'b0;
`else
            m_ov = 1'b0;
`endif
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_ready",  8'(cif.cmd_ready), 8'(!m_busy));
            chk("m_acc",    8'(acc), 8'(m_acc));
            chk("m_flags",  8'({flag_c, flag_n, flag_z, flag_v}), 8'(m_flags));
            chk("m_done",   8'(done), 8'(m_done));
            chk("m_alu_a",  8'(alu_a), 8'(m_acc));
            chk("m_alu_b",  8'(alu_b), 8'(m_b));
            chk("m_alu_op", 8'(alu_op), 8'(m_op));
            chk("m_ov",     8'(ov_sticky), 8'(m_ov));
        end
    end

    task automatic drive(input logic v, input logic ld, input logic [2:0] op, input logic [3:0] b);
        cif.cmd_valid = v; cif.cmd_ld = ld; cif.cmd_op = op; cif.cmd_b = b;
    endtask

    // Wait to the next falling edge (outputs settled after the prior rising edge).
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b1;
        step();
    endtask

    int dones;
    logic exp_ov;

    initial begin
        reset_n = 1'b0;
        ov_clr  = 1'b0;
        drive(0, 0, 3'd0, 4'h0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        chk_en = 1;
        step();

        // Reset state
        chk("rst_acc",   8'(acc), 8'(4'b0000));
        chk("rst_flags", 8'({flag_c, flag_n, flag_z, flag_v}), 8'h0);
        chk("rst_ready", 8'(cif.cmd_ready), 8'd1);
        chk("rst_done",  8'(done), 8'd0);
        chk("rst_op",    8'(alu_op), 8'd0);

        // Load 7 then add 1
        drive(1, 1, 3'd0, 4'b0111);
        step();
        chk("ld7_acc",  8'(acc), 8'(4'b0111));
        chk("ld7_done", 8'(done), 8'd1);
        drive(1, 0, 3'b110, 4'b0001);
        step();
        drive(0, 0, 3'd0, 4'h0);
        chk("add_ready_exec", 8'(cif.cmd_ready), 8'd0);
        chk("add_done_exec",  8'(done), 8'd0);
        step();
        chk("add_acc",   8'(acc), 8'(4'b1000));
        chk("add_flags", 8'({flag_c, flag_n, flag_z, flag_v}), 8'(4'b0101));
        chk("add_done",  8'(done), 8'd1);
        step();
        chk("add_done_once", 8'(done), 8'd0);

        // Subtract 8 from 8
        drive(1, 0, 3'b111, 4'b1000);
        step();
        drive(1, 1, 3'd0, 4'hf);   // ignored while busy
        chk("sub_alu_a",  8'(alu_a), 8'(4'b1000));
        chk("sub_alu_b",  8'(alu_b), 8'(4'b1000));
        chk("sub_alu_op", 8'(alu_op), 8'(3'b111));
        #1 drive(0, 0, 3'd0, 4'h0);
        step();
        chk("sub_acc",   8'(acc), 8'(4'b0000));
        chk("sub_flags", 8'({flag_c, flag_n, flag_z, flag_v}), 8'(4'b1010));

        // Backpressure: valid held four cycles
        dones = 0;
        drive(1, 0, 3'b110, 4'b0001);
        for (int i = 0; i < 4; i++) begin
            chk("bp_ready", 8'(cif.cmd_ready), 8'((i % 2) == 0));
            step();
            if (done) dones++;
        end
        drive(0, 0, 3'd0, 4'h0);
        step();
        if (done) dones++;
        chk("bp_dones", 8'(dones), 8'd2);
        chk("bp_acc",   8'(acc), 8'(4'b0010));

        // Reset in the middle of EXEC
        drive(1, 1, 3'd0, 4'b0101);
        step();
        drive(1, 0, 3'b110, 4'b0011);
        step();
        drive(0, 0, 3'd0, 4'h0);
        chk("mid_in_exec", 8'(cif.cmd_ready), 8'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_acc",   8'(acc), 8'(ACC_INIT));
        chk("mid_done",  8'(done), 8'd0);
        chk("mid_ready", 8'(cif.cmd_ready), 8'd1);
        step();
        #2 reset_n = 1'b1;
        step();
        chk("mid_acc_after",  8'(acc), 8'(ACC_INIT));
        chk("mid_done_after", 8'(done), 8'd0);

        // Sticky overflow
`ifdef ACC_STICKY_OV_EN
        exp_ov = 1'b1;
`else
        exp_ov = 1'b0;
`endif
        drive(1, 1, 3'd0, 4'b0111);
        step();
        drive(1, 0, 3'b110, 4'b0001);
        step();
        drive(0, 0, 3'd0, 4'h0);
        step();
        chk("ov_set", 8'(ov_sticky), 8'(exp_ov));
        drive(1, 1, 3'd0, 4'b0001);
        step();
        drive(1, 0, 3'b010, 4'b0001);
        step();
        drive(0, 0, 3'd0, 4'h0);
        step();
        chk("ov_hold", 8'(ov_sticky), 8'(exp_ov));
        ov_clr = 1'b1;
        step();
        ov_clr = 1'b0;
        chk("ov_clr", 8'(ov_sticky), 8'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                drive(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0),
                      3'($urandom), 4'($urandom));
                ov_clr = 1'($urandom_range(0, 7) == 0);
                step();
            end
        end
        drive(0, 0, 3'd0, 4'h0);
        ov_clr = 1'b0;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit reached");
        $fatal(1);
    end
endmodule
